// File: rtl/chan_fifo_8x.sv
// ============================================================================
//  chan_fifo_8x : 8-lane synchronous FIFO with a shared pointer pair and early full
//  Rev 1.0
// ============================================================================
`default_nettype none

module chan_fifo_8x #(
  parameter int DWIDTH      = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DWIDTH-1:0]     wr_data_0,
  input  logic [DWIDTH-1:0]     wr_data_1,
  input  logic [DWIDTH-1:0]     wr_data_2,
  input  logic [DWIDTH-1:0]     wr_data_3,
  input  logic [DWIDTH-1:0]     wr_data_4,
  input  logic [DWIDTH-1:0]     wr_data_5,
  input  logic [DWIDTH-1:0]     wr_data_6,
  input  logic [DWIDTH-1:0]     wr_data_7,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DWIDTH-1:0]     rd_data_0,
  output logic [DWIDTH-1:0]     rd_data_1,
  output logic [DWIDTH-1:0]     rd_data_2,
  output logic [DWIDTH-1:0]     rd_data_3,
  output logic [DWIDTH-1:0]     rd_data_4,
  output logic [DWIDTH-1:0]     rd_data_5,
  output logic [DWIDTH-1:0]     rd_data_6,
  output logic [DWIDTH-1:0]     rd_data_7,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam int                WORD_W     = 8 * DWIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH - FULL_MARGIN);

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     wr_word;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance depends only on the current count: no pass-through at full, no bypass at empty.
  assign wr_acc  = wr_en && (count != COUNT_MAX);
  assign rd_acc  = rd_en && (count != '0);
  assign wr_word = {wr_data_7, wr_data_6, wr_data_5, wr_data_4,
                    wr_data_3, wr_data_2, wr_data_1, wr_data_0};

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_word   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_word <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      rd_valid <= rd_acc;
      if (wr_en && (count == COUNT_MAX)) begin
        overflow <= 1'b1;
      end
      if (rd_en && (count == '0)) begin
        underflow <= 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count >= FULL_LEVEL);

  assign rd_data_0 = rd_word[0*DWIDTH +: DWIDTH];
  assign rd_data_1 = rd_word[1*DWIDTH +: DWIDTH];
  assign rd_data_2 = rd_word[2*DWIDTH +: DWIDTH];
  assign rd_data_3 = rd_word[3*DWIDTH +: DWIDTH];
  assign rd_data_4 = rd_word[4*DWIDTH +: DWIDTH];
  assign rd_data_5 = rd_word[5*DWIDTH +: DWIDTH];
  assign rd_data_6 = rd_word[6*DWIDTH +: DWIDTH];
  assign rd_data_7 = rd_word[7*DWIDTH +: DWIDTH];

endmodule

`default_nettype wire
